// File: rtl/apb_master_bridge_p.sv
// Parametrised APB master bridge: valid/ready request side, one-hot PSEL decode, single-cycle response strobe.
// Optional ACCESS wait timeout is compiled in with `define APB_TIMEOUT_EN (adds parameter TIMEOUT_CYC).
module apb_master_bridge_p #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLV_AW     = 12
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 256
`endif
) (
  input  logic                         PCLK,
  input  logic                         RESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [IDX_W:0] NSLV = NUM_SLAVES[IDX_W:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUM_SLAVES-1:0]   r_psel, w_psel_nxt;
  logic                    r_penable, w_penable_nxt;
  logic                    r_pwrite, w_pwrite_nxt;
  logic [ADDR_W-1:0]       r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0]       r_pwdata, w_pwdata_nxt;
  logic                    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]       r_rsp_rdata, w_rsp_rdata_nxt;
  logic                    r_rsp_err, w_rsp_err_nxt;
  // A decode error accepted on a completion edge must wait one cycle for the response slot.
  logic                    r_err_pend, w_err_pend_nxt;
  logic                    w_req_ready;

  logic [IDX_W-1:0]        w_req_idx;
  logic                    w_dec_ok;
  logic [NUM_SLAVES-1:0]   w_new_psel;
  logic                    w_sel_ready;
  logic                    w_sel_err;
  logic [DATA_W-1:0]       w_sel_rdata;
  logic                    w_timeout;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_wait_cnt;

  // ACCESS wait counter, zero on the first ACCESS cycle
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_wait_cnt <= {TO_W{1'b0}};
    end else if (r_state != ST_ACCESS) begin
      r_wait_cnt <= {TO_W{1'b0}};
    end else begin
      r_wait_cnt <= r_wait_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_timeout = (r_wait_cnt == TO_W'(TIMEOUT_CYC - 1)) && !w_sel_ready;
`else
  assign w_timeout = 1'b0;
`endif

  // Request address decode into slave index and one-hot select
  always_comb begin
    w_req_idx = {IDX_W{1'b0}};
    if (NUM_SLAVES > 1) begin
      w_req_idx = req_addr[SLV_AW +: IDX_W];
    end else begin
      w_req_idx = {IDX_W{1'b0}};
    end
    w_dec_ok   = ({1'b0, w_req_idx} < NSLV);
    w_new_psel = {NUM_SLAVES{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_new_psel[i] = (w_req_idx == i[IDX_W-1:0]);
    end
  end

  // Observe only the currently selected slave (PSEL is one-hot)
  always_comb begin
    w_sel_ready = |(PREADY & r_psel);
    w_sel_err   = |(PSLVERR & r_psel);
    w_sel_rdata = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_sel_rdata = w_sel_rdata | ({DATA_W{r_psel[i]}} & PRDATA[i*DATA_W +: DATA_W]);
    end
  end

  // Next-state and next-output logic for the APB sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = {DATA_W{1'b0}};
    w_rsp_err_nxt   = 1'b0;
    w_err_pend_nxt  = 1'b0;
    w_req_ready     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_req_ready   = 1'b1;
        w_psel_nxt    = {NUM_SLAVES{1'b0}};
        w_penable_nxt = 1'b0;
        if (r_err_pend) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_rsp_valid_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (w_sel_ready || w_timeout) begin
          // A timeout never chains into a back-to-back transfer.
          w_req_ready     = w_sel_ready;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = w_sel_err | w_timeout;
          w_rsp_rdata_nxt = (!r_pwrite && !w_sel_err && !w_timeout) ? w_sel_rdata : {DATA_W{1'b0}};
          w_state_nxt     = ST_IDLE;
          w_psel_nxt      = {NUM_SLAVES{1'b0}};
          w_penable_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_psel_nxt    = {NUM_SLAVES{1'b0}};
        w_penable_nxt = 1'b0;
      end
    endcase

    if (w_req_ready && req_valid) begin
      if (w_dec_ok) begin
        w_state_nxt   = ST_SETUP;
        w_psel_nxt    = w_new_psel;
        w_penable_nxt = 1'b0;
        w_pwrite_nxt  = req_write;
        w_paddr_nxt   = req_addr;
        w_pwdata_nxt  = req_wdata;
      end else begin
        w_state_nxt   = ST_IDLE;
        w_psel_nxt    = {NUM_SLAVES{1'b0}};
        w_penable_nxt = 1'b0;
        if (w_rsp_valid_nxt) begin
          w_err_pend_nxt = 1'b1;
        end else begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = {DATA_W{1'b0}};
        end
      end
    end else begin
      w_err_pend_nxt = w_err_pend_nxt;
    end
  end

  // State and registered APB/response outputs
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_psel      <= {NUM_SLAVES{1'b0}};
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= {ADDR_W{1'b0}};
      r_pwdata    <= {DATA_W{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
      r_err_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_err_pend  <= w_err_pend_nxt;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule

// File: doc/apb_master_bridge_p.md
Name: apb_master_bridge_p

Overview:
Parametrised AMBA3 APB master bridge, the successor to the fixed 8-bit single-slave bridge. It accepts requests from the system side through a valid/ready handshake. It decodes each address to one of NUM_SLAVES one-hot PSEL lines and runs the SETUP/ACCESS sequence, honouring PREADY wait states and PSLVERR. It returns read data and error status on a single-cycle response strobe. It sits between the system interconnect and the APB peripheral segment.

Parameters:
ADDR_W, 16, PADDR / req_addr width (>= SLV_AW + clog2(NUM_SLAVES))
DATA_W, 32, PWDATA/PRDATA width per slave
NUM_SLAVES, 4, number of PSEL lines (1..16)
SLV_AW, 12, address bits per slave region; slave index = req_addr[SLV_AW +: clog2(NUM_SLAVES)] (index 0 when NUM_SLAVES=1)

Ports:
PCLK  in  1  clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  bridge accepts request this cycle
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  PSLVERR or decode error, valid with rsp_valid
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  access phase
PWRITE  out  1  direction
PADDR  out  ADDR_W  address
PWDATA  out  DATA_W  write data
PRDATA  in  NUM_SLAVES*DATA_W  concatenated slave read data, slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (RESET=1 at rising edge): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err all 0. Reset mid-transfer aborts it with no response pulse.
- All APB outputs and rsp_* are registered. req_ready is combinational from state and PREADY.
- States: IDLE, SETUP, ACCESS.
- IDLE: req_ready=1.
  - Accept with a valid decode → SETUP. Latch addr, wdata and write into the PADDR/PWDATA/PWRITE registers and set PSEL[idx]=1, all on the accept edge.
  - Accept with idx >= NUM_SLAVES → stay IDLE, no PSEL; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- SETUP: PSEL held, PENABLE=0, req_ready=0. Unconditionally → ACCESS with PENABLE=1.
- ACCESS: PADDR/PWDATA/PWRITE/PSEL stable. Only the selected slave's PREADY/PSLVERR/PRDATA are observed.
  - PREADY[idx]=0: hold, req_ready=0. Wait states are unbounded unless APB_TIMEOUT_EN is defined.
  - PREADY[idx]=1: transfer completes. Next cycle rsp_valid=1, rsp_err=PSLVERR[idx], rsp_rdata=PRDATA slice if read and not err, else 0. req_ready=1 in this same cycle.
  - Completion with req_valid=1 and valid decode: back-to-back → SETUP with the new PSEL/PADDR, PENABLE=0. No IDLE cycle.
  - Completion with req_valid=1 and bad decode: → IDLE, error response on the following cycle.
  - Completion with req_valid=0: → IDLE, PSEL=0, PENABLE=0.
- Minimum latency accept→rsp_valid: 3 cycles with a zero-wait slave. Throughput: one transfer per 2 cycles back-to-back.
- PSEL never has more than one bit set. PENABLE=1 only while PSEL≠0.
- req_* inputs are ignored when req_ready=0. Requester must hold req_valid and its payload until accepted.

Optional Feature:
APB_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT_CYC (default 256) and an ACCESS wait counter, cleared on entry to ACCESS.
- If the counter reaches TIMEOUT_CYC with PREADY[idx] still 0: force completion, rsp_err=1, rsp_rdata=0, return to IDLE (no back-to-back on a timeout).
- Not defined: no counter, and ACCESS waits indefinitely.

Test Plan:
- Reset then write: req addr=0x1010, wdata=0xDEADBEEF, PREADY=1 → PSEL=4'b0010 SETUP 1 cycle, PENABLE next cycle, PWRITE=1, PADDR=0x1010; rsp_valid 3 cycles after accept, rsp_err=0.
- Read with 3 wait states from slave 2 (addr=0x2004, PRDATA slice=0x12345678) → PENABLE held 4 cycles; rsp_rdata=0x12345678, rsp_err=0.
- Back-to-back write slave 0 then read slave 3 with req_valid held → PSEL 4'b0001 → 4'b1000 with no IDLE gap, PENABLE low exactly one cycle between.
- PSLVERR[1]=1 on completion of a read → rsp_err=1, rsp_rdata=0. Decode error with NUM_SLAVES=3, addr=0x3000 → no PSEL, rsp_valid+rsp_err one cycle after accept.
- RESET asserted during ACCESS wait → next cycle all outputs 0, state IDLE, no rsp_valid. APB_TIMEOUT_EN with TIMEOUT_CYC=8 and PREADY stuck 0 → rsp_err=1 after 8 ACCESS cycles, PSEL cleared.
